// File: rtl/des_pkg.sv
// des_pkg: DES key schedule tables, widths, state encoding and rotate helpers
package des_pkg;
  localparam int KEY_W = 64;
  localparam int CD_W = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUND_W = 5;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  function automatic logic [0:CD_W-1] rotl(input logic [0:CD_W-1] x, input logic [1:0] n);
    return n == 2'd2 ? {x[2:CD_W-1], x[0:1]} : n == 2'd1 ? {x[1:CD_W-1], x[0]} : x;
  endfunction
  function automatic logic [0:CD_W-1] rotr(input logic [0:CD_W-1] x, input logic [1:0] n);
    return n == 2'd2 ? {x[CD_W-2:CD_W-1], x[0:CD_W-3]} : n == 2'd1 ? {x[CD_W-1], x[0:CD_W-2]} : x;
  endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational PC-2 selection of a 48-bit subkey from 56-bit C||D
module des_pc2
  import des_pkg::*;
(
  input  logic [0:2*CD_W-1]   cd,
  output logic [0:SUBKEY_W-1] key
);
  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign key[i] = cd[PC2[i]-1];
  end
endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: iterative DES subkey generator with valid/ready handshake
module des_key_sched
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [0:KEY_W-1]    key_in,
  input  logic                decrypt,
  input  logic                key_ready,
  output logic [0:SUBKEY_W-1] key,
  output logic [ROUND_W-1:0]  round,
  output logic                key_valid,
  output logic                busy,
  output logic                done
);
  state_t state;
  logic [0:CD_W-1] c, d;
  logic dec;
  logic [0:2*CD_W-1] pc1;
  logic acc;
  for (genvar i = 0; i < 2*CD_W; i++) begin : g_pc1
    assign pc1[i] = key_in[PC1[i]-1];
  end
  assign acc = state == RUN && key_ready;
  assign key_valid = state == RUN;
  assign busy = state == RUN;
  des_pc2 u_pc2 (.cd({c, d}), .key(key));
  // load C/D on start, then step them once per accepted subkey
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c <= '0;
      d <= '0;
      dec <= 1'b0;
      round <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        c <= decrypt ? pc1[0:CD_W-1] : rotl(pc1[0:CD_W-1], 2'd1);
        d <= decrypt ? pc1[CD_W:2*CD_W-1] : rotl(pc1[CD_W:2*CD_W-1], 2'd1);
        dec <= decrypt;
        round <= 5'd1;
        state <= RUN;
      end else if (acc) begin
        if (round == 5'd16) begin
          state <= IDLE;
          round <= '0;
          done <= 1'b1;
        end else begin
          round <= round + 5'd1;
          c <= dec ? rotr(c, DEC_SHIFT[round[3:0]]) : rotl(c, ENC_SHIFT[round[3:0]]);
          d <= dec ? rotr(d, DEC_SHIFT[round[3:0]]) : rotl(d, ENC_SHIFT[round[3:0]]);
        end
      end
    end
  end
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: scoreboard bench for the DES key schedule
module tb_des_key_sched;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, decrypt = 1'b0, key_ready = 1'b0;
  logic [63:0] key_in = '0;
  logic [47:0] key;
  logic [4:0] round;
  logic key_valid, busy, done;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [4:0] r; logic [47:0] k;} exp_t;
  exp_t sb[$];
  localparam logic [63:0] KA = 64'h133457799BBCDFF1;
  localparam logic [63:0] KP = 64'h123456789ABCDEF0;
  localparam logic [63:0] KQ = 64'h133557799BBDDFF1;
  localparam int TPC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int TPC2 [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  des_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .decrypt(decrypt),
    .key_ready(key_ready), .key(key), .round(round), .key_valid(key_valid),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [47:0] model(input logic [63:0] k, input int n);
    logic [55:0] p;
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] o;
    int m;
    m = CUM[n-1];
    for (int j = 0; j < 56; j++) p[55-j] = k[64-TPC1[j]];
    c = p[55:28];
    d = p[27:0];
    c = (c << m) | (c >> (28 - m));
    d = (d << m) | (d >> (28 - m));
    cd = {c, d};
    for (int j = 0; j < 48; j++) o[47-j] = cd[56-TPC2[j]];
    return o;
  endfunction

  function automatic logic [47:0] exp_key(input logic [63:0] k, input int n);
    if (k == KA && n == 1) return 48'h1B02EFFC7072;
    if (k == KA && n == 2) return 48'h79AED9DBC9E5;
    if (k == KA && n == 16) return 48'hCB3D8B0E17F5;
    return model(k, n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_round"}, 64'(round), 0);
    chk({tag, "_key"}, 64'(key), 0);
    chk({tag, "_valid"}, 64'(key_valid), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  task automatic run_sched(input logic [63:0] k, input logic dec, input bit rnd, input bit poke, input int abort_at);
    int budget;
    bit acc;
    budget = 0;
    start = 1'b1;
    key_in = k;
    decrypt = dec;
    for (int n = 1; n <= 16; n++) sb.push_back(exp_t'{r: 5'(n), k: exp_key(k, dec ? 17 - n : n)});
    @(posedge clk) #1;
    start = 1'b0;
    while (sb.size() > 0 && budget < 200) begin
      budget++;
      chk("valid", 64'(key_valid), 1);
      chk("busy", 64'(busy), 1);
      chk("done_in_run", 64'(done), 0);
      chk("round", 64'(round), 64'(sb[0].r));
      chk("key", 64'(key), 64'(sb[0].k));
      if (int'(sb[0].r) == abort_at) begin
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        sb.delete();
        chk_idle("abort");
        return;
      end
      if (poke && sb[0].r == 5'd5) begin
        start = 1'b1;
        key_in = ~k;
        decrypt = ~dec;
      end
      acc = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      key_ready = acc;
      @(posedge clk) #1;
      start = 1'b0;
      key_in = k;
      decrypt = dec;
      if (acc) void'(sb.pop_front());
    end
    chk("drain", 64'(sb.size()), 0);
    sb.delete();
    key_ready = 1'b0;
    chk("done", 64'(done), 1);
    chk("busy_at_done", 64'(busy), 0);
    chk("valid_at_done", 64'(key_valid), 0);
    chk("round_at_done", 64'(round), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    run_sched(KA, 1'b0, 1'b0, 1'b0, 0);
    run_sched(KA, 1'b1, 1'b0, 1'b0, 0);
    run_sched(KA, 1'b0, 1'b1, 1'b0, 0);
    run_sched(KA, 1'b1, 1'b1, 1'b0, 0);
    run_sched(KP, 1'b0, 1'b0, 1'b0, 0);
    run_sched(KQ, 1'b0, 1'b1, 1'b0, 0);
    run_sched(KQ, 1'b1, 1'b1, 1'b0, 0);
    run_sched(KA, 1'b0, 1'b0, 1'b1, 0);
    run_sched({$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 7);
    rst = 1'b1;
    start = 1'b1;
    key_in = KA;
    @(posedge clk) #1;
    rst = 1'b0;
    start = 1'b0;
    chk_idle("rst_and_start");
    run_sched(KA, 1'b0, 1'b0, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
